trng_reader: RTL and testbench
==============================

TRNG_READER -- requirements
Module: trng_reader

Interface
REQ-001 Parameter WORD_BYTES, default 4, number of 8-bit samples packed per output word (legal 1..8).
REQ-002 Parameter TIMEOUT, default 255, WAIT-state cycles allowed before a sample request is abandoned (legal 1..65535).
REQ-003 Parameter REP_LIMIT, default 4, identical consecutive samples that trip the health test (legal 2..15).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  level request for words; sampled in IDLE.
REQ-007 trn_start  output  1  one-cycle pulse requesting one byte from the generator.
REQ-008 trn_data  input  8  generator byte, valid when trn_done=1.
REQ-009 trn_done  input  1  generator completion, level, may stay high several cycles.
REQ-010 word  output  8*WORD_BYTES  packed random word, byte 0 in bits [7:0].
REQ-011 word_valid  output  1  word holds a complete word.
REQ-012 word_ready  input  1  downstream accept; transfer when word_valid & word_ready.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err_timeout  output  1  sticky; a sample request timed out.
REQ-015 health_fail  output  1  sticky; repetition-count test tripped.

Function
REQ-016 FSM states IDLE, ARM, WAIT, CAPT, OUT; exactly one active per cycle.
REQ-017 IDLE -> ARM when req=1; otherwise stay.
REQ-018 ARM: hold until trn_done=0, then assert trn_start for exactly that cycle and move to WAIT.
REQ-019 WAIT: timeout counter increments each cycle; first cycle with trn_done=1 -> CAPT, counter cleared.
REQ-020 WAIT: counter reaching TIMEOUT with trn_done=0 -> set err_timeout, clear counter, return to ARM (retry same byte slot); byte_cnt unchanged.
REQ-021 CAPT: store trn_data (value present on the WAIT->CAPT edge) into slot byte_cnt; if byte_cnt=WORD_BYTES-1 -> OUT and clear byte_cnt, else increment byte_cnt and -> ARM.
REQ-022 Latency: trn_start pulse to capture = generator delay + 1 cycle; last capture to word_valid = 1 cycle.
REQ-023 OUT: word_valid=1, word stable until transfer; on transfer -> ARM if req=1, else IDLE.
REQ-024 word_ready while word_valid=0 has no effect; word_valid never drops without a transfer except by reset.
REQ-025 req deasserted mid-word does not abort; the current word completes and is presented.
REQ-026 byte_cnt width ceil(log2(WORD_BYTES))+1; timeout counter 16 bits; no wrap beyond TIMEOUT.

Reset
REQ-027 reset=1 forces IDLE asynchronously; trn_start=0, word=0, word_valid=0, busy=0, err_timeout=0, health_fail=0, counters 0.
REQ-028 Reset mid-word discards all captured bytes; no partial word is ever presented.
REQ-029 Sticky flags clear only by reset.

Configuration
REQ-030 Macro TRNG_READER_HEALTH_EN compiles in the repetition-count test.
REQ-031 With it: every captured byte compared to previous captured byte; run count increments on match, resets to 1 on mismatch; run count reaching REP_LIMIT sets health_fail; run state cleared by reset only; data path unaffected.
REQ-032 Without it: health_fail tied 0, no comparison logic or history register.

Structure
REQ-033 Shared package trng_pkg: FSM state enum, default values of WORD_BYTES, TIMEOUT, REP_LIMIT.
REQ-034 One sub-module trng_rct (repetition-count test), instantiated only under TRNG_READER_HEALTH_EN.

Verification
REQ-035 WORD_BYTES=4, generator returns 0x11,0x22,0x33,0x44 with 3-cycle delay, word_ready=1 -> word=0x44332211, word_valid one cycle, four trn_start pulses.
REQ-036 trn_done never asserted, TIMEOUT=8 -> err_timeout=1 after 8 WAIT cycles, trn_start re-pulses, busy stays 1.
REQ-037 word_ready=0 for 10 cycles after word_valid -> word stable, no trn_start pulses until transfer.
REQ-038 reset asserted after 2 of 4 bytes, then req=1 -> next word contains only post-reset bytes, all outputs 0 during reset.
REQ-039 TRNG_READER_HEALTH_EN, REP_LIMIT=4, generator returns 0xA5 four times -> health_fail=1 after 4th capture; without macro health_fail=0.
REQ-040 trn_done held high 5 cycles per byte -> exactly one capture per byte, ARM waits for trn_done=0 before next pulse.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word reader: FSM state encoding and parameter defaults.
package trng_pkg;

    localparam int WORD_BYTES_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;
    localparam int REP_LIMIT_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Width of the byte-slot counter: ceil(log2(n)) + 1.
    function automatic int byte_cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/trng_reader_if.sv
// Generator and word-output signals of trng_reader; slave is the reader, master the surrounding logic.
interface trng_reader_if #(
    parameter int WORD_BYTES = trng_pkg::WORD_BYTES_DEF
);
    logic                    req;
    logic                    trn_start;
    logic [7:0]              trn_data;
    logic                    trn_done;
    logic [8*WORD_BYTES-1:0] word;
    logic                    word_valid;
    logic                    word_ready;
    logic                    busy;
    logic                    err_timeout;
    logic                    health_fail;

    modport slave (
        input  req, trn_data, trn_done, word_ready,
        output trn_start, word, word_valid, busy, err_timeout, health_fail
    );

    modport master (
        output req, trn_data, trn_done, word_ready,
        input  trn_start, word, word_valid, busy, err_timeout, health_fail
    );
endinterface

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a run of REP_LIMIT identical consecutive captured bytes.
module trng_rct
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_fail
);

    localparam logic [4:0] LIMIT = 5'(REP_LIMIT);

    logic [7:0] r_prev;
    logic [3:0] r_run;
    logic       r_have;
    logic       r_fail;
    logic [4:0] w_run_inc;
    logic       w_repeat;

    assign w_run_inc = {1'b0, r_run} + 5'd1;
    assign w_repeat  = r_have && (i_data == r_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 8'd0;
            r_run  <= 4'd0;
            r_have <= 1'b0;
            r_fail <= 1'b0;
        end else if (i_valid) begin
            r_prev <= i_data;
            r_have <= 1'b1;
            if (w_repeat) begin
                // Saturate at the limit so a long run cannot wrap the counter.
                if (w_run_inc <= LIMIT) begin
                    r_run <= w_run_inc[3:0];
                end
                if (w_run_inc >= LIMIT) begin
                    r_fail <= 1'b1;
                end
            end else begin
                r_run <= 4'd1;
            end
        end
    end

    assign o_fail = r_fail;

endmodule

// File: rtl/trng_reader.sv
// Collects WORD_BYTES generator bytes into a word with request timeout and optional health test.
// Define TRNG_READER_HEALTH_EN to compile in the repetition-count test (trng_rct).
module trng_reader
    import trng_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    trng_reader_if.slave bus
);

    localparam int                  CNT_W     = byte_cnt_width(WORD_BYTES);
    localparam logic [CNT_W-1:0]    LAST_SLOT = CNT_W'(WORD_BYTES - 1);
    localparam logic [15:0]         TMO_LAST  = 16'(TIMEOUT - 1);

    if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_word_bytes
        $error("trng_reader: WORD_BYTES must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("trng_reader: TIMEOUT must be 1..65535");
    end
    if (REP_LIMIT < 2 || REP_LIMIT > 15) begin : g_bad_rep_limit
        $error("trng_reader: REP_LIMIT must be 2..15");
    end

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [15:0]             r_tmo_cnt;
    logic [7:0]              r_sample;
    logic [8*WORD_BYTES-1:0] r_acc;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [8*WORD_BYTES-1:0] w_acc_next;
    logic                    r_err_timeout;
    logic                    w_trn_start;
    logic                    w_timeout;
    logic                    w_last_slot;
    logic                    w_health_fail;

    assign w_last_slot = (r_byte_cnt == LAST_SLOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_trn_start  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                // A generator still holding done from the last byte must drop it first.
                if (!bus.trn_done) begin
                    w_trn_start  = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.trn_done) begin
                    w_state_next = ST_CAPT;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_ARM;
                end
            end
            ST_CAPT: begin
                w_state_next = w_last_slot ? ST_OUT : ST_ARM;
            end
            ST_OUT: begin
                if (bus.word_ready) begin
                    w_state_next = bus.req ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Merge the held sample into its slot of the accumulator.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_slot
        assign w_acc_next[8*gi +: 8] = (r_byte_cnt == CNT_W'(gi)) ? r_sample : r_acc[8*gi +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt    <= '0;
            r_tmo_cnt     <= 16'd0;
            r_sample      <= 8'd0;
            r_acc         <= '0;
            r_word        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == ST_WAIT && !bus.trn_done && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= 16'd0;
            end

            if (r_state == ST_WAIT && bus.trn_done) begin
                r_sample <= bus.trn_data;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end

            // The output word only changes when a complete word has been assembled.
            if (r_state == ST_CAPT) begin
                r_acc <= w_acc_next;
                if (w_last_slot) begin
                    r_byte_cnt <= '0;
                    r_word     <= w_acc_next;
                end else begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef TRNG_READER_HEALTH_EN
    trng_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rct (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_state == ST_CAPT),
        .i_data  (r_sample),
        .o_fail  (w_health_fail)
    );
`else
    assign w_health_fail = 1'b0;
`endif

    assign bus.trn_start   = w_trn_start;
    assign bus.word        = r_word;
    assign bus.word_valid  = (r_state == ST_OUT);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.err_timeout = r_err_timeout;
    assign bus.health_fail = w_health_fail;

endmodule

// File: tb/tb_trng_reader.sv
// Randomized scoreboard bench for trng_reader: generator model feeds bytes, a byte-list model predicts words.
module tb_trng_reader;
    import trng_pkg::*;

    localparam int WB  = 4;
    localparam int TMO = 8;
    localparam int RL  = 4;
`ifdef TRNG_READER_HEALTH_EN
    localparam logic HEALTH_ON = 1'b1;
`else
    localparam logic HEALTH_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    trng_reader_if #(.WORD_BYTES(WB)) bus ();

    trng_reader #(
        .WORD_BYTES (WB),
        .TIMEOUT    (TMO),
        .REP_LIMIT  (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every byte the generator hands out is captured, WB bytes form a word.
    logic [7:0]  part_q[$];
    logic [31:0] exp_q[$];
    int          run_len    = 0;
    logic [7:0]  last_b     = 8'd0;
    bit          have_last  = 1'b0;
    logic        exp_health = 1'b0;

    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] w;
        part_q.push_back(b);
        if (part_q.size() == WB) begin
            w = 32'd0;
            for (int i = 0; i < WB; i++) w = w | (32'(part_q[i]) << (8 * i));
            exp_q.push_back(w);
            part_q.delete();
        end
        if (have_last && b == last_b) run_len++;
        else run_len = 1;
        last_b    = b;
        have_last = 1'b1;
        if (HEALTH_ON && run_len >= RL) exp_health = 1'b1;
    endfunction

    function automatic void model_clear();
        part_q.delete();
        exp_q.delete();
        run_len    = 0;
        have_last  = 1'b0;
        exp_health = 1'b0;
    endfunction

    // Generator model: answers each trn_start after a delay, holding done for several cycles.
    bit         gen_drop  = 1'b0;
    bit         gen_rand  = 1'b0;
    int         gen_delay = 3;
    int         gen_hold  = 1;
    logic [7:0] force_q[$];

    initial begin : gen
        int         wait_c;
        int         hold_c;
        int         cur_hold;
        bit         pending;
        bit         st;
        logic [7:0] b;
        bus.trn_done = 1'b0;
        bus.trn_data = 8'd0;
        wait_c = 0; hold_c = 0; cur_hold = 1; pending = 1'b0;
        forever begin
            @(negedge clk);
            st = bus.trn_start && !reset;
            @(posedge clk);
            #1;
            if (reset) begin
                bus.trn_done = 1'b0;
                pending = 1'b0;
                hold_c  = 0;
            end else begin
                if (hold_c > 0) begin
                    hold_c--;
                    if (hold_c == 0) bus.trn_done = 1'b0;
                end
                if (st && !gen_drop) begin
                    pending  = 1'b1;
                    wait_c   = (gen_rand ? int'($urandom_range(1, 5)) : gen_delay) - 1;
                    cur_hold = gen_rand ? int'($urandom_range(1, 4)) : gen_hold;
                end else if (pending) begin
                    wait_c--;
                end
                if (pending && wait_c <= 0) begin
                    pending = 1'b0;
                    b = (force_q.size() != 0) ? force_q.pop_front() : 8'($urandom_range(0, 255));
                    bus.trn_data = b;
                    bus.trn_done = 1'b1;
                    hold_c = cur_hold;
                    model_byte(b);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer and watches the hold-off rules.
    int          start_cnt    = 0;
    int          xfer_cnt     = 0;
    int          valid_cycles = 0;
    logic [31:0] last_word    = 32'd0;
    logic [31:0] prev_word    = 32'd0;
    bit          hold_prev    = 1'b0;

    initial begin : mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (bus.trn_start) start_cnt++;
                if (bus.word_valid) begin
                    valid_cycles++;
                    check("start_while_valid", 64'(bus.trn_start), 64'd0);
                end
                if (hold_prev) begin
                    check("valid_held", 64'(bus.word_valid), 64'd1);
                    check("word_stable", 64'(bus.word), 64'(prev_word));
                end
                if (bus.word_valid && bus.word_ready) begin
                    xfer_cnt++;
                    last_word = bus.word;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(bus.word_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 64'(bus.word), 64'(e));
                    end
                    $display("xfer %0d word=0x%08h t=%0t", xfer_cnt, bus.word, $time);
                end
                hold_prev = bus.word_valid && !bus.word_ready;
                prev_word = bus.word;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 2000) begin
            tick();
            t++;
        end
        check(name, 64'(t >= 2000), 64'd0);
    endtask

    task automatic run_words(input int n, input bit rnd_ready);
        int base = xfer_cnt;
        int s0   = start_cnt;
        int t    = 0;
        bus.req = 1'b1;
        while (xfer_cnt < base + n && t < 3000) begin
            tick();
            t++;
            if (rnd_ready) bus.word_ready = 1'($urandom_range(0, 1));
        end
        check("words_in_time", 64'(t >= 3000), 64'd0);
        bus.req        = 1'b0;
        bus.word_ready = 1'b1;
        wait_idle("drain_idle");
        check("starts_per_word", 64'(start_cnt - s0), 64'(WB * (xfer_cnt - base)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trn_start"}, 64'(bus.trn_start), 64'd0);
        check({tag, "_word"}, 64'(bus.word), 64'd0);
        check({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_err_timeout"}, 64'(bus.err_timeout), 64'd0);
        check({tag, "_health_fail"}, 64'(bus.health_fail), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        int v0;
        int t;
        bus.req        = 1'b0;
        bus.word_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Fixed bytes, 3-cycle generator delay, always ready
        force_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        gen_rand = 1'b0; gen_delay = 3; gen_hold = 1;
        s0 = start_cnt; v0 = valid_cycles; t = 0;
        bus.req = 1'b1;
        while (start_cnt == s0 && t < 100) begin tick(); t++; end
        bus.req = 1'b0;
        wait_idle("basic_idle");
        check("basic_starts", 64'(start_cnt - s0), 64'd4);
        check("basic_valid_cycles", 64'(valid_cycles - v0), 64'd1);
        check("basic_word", 64'(last_word), 64'h44332211);

        // trn_done held high for 5 cycles per byte
        gen_delay = 2; gen_hold = 5;
        run_words(2, 1'b0);

        // Randomized delays, hold times, data and backpressure
        gen_rand = 1'b1;
        run_words(6, 1'b1);

        // Backpressure: word held for 10 cycles, no new requests issued
        bus.word_ready = 1'b0;
        bus.req = 1'b1;
        t = 0;
        while (!bus.word_valid && t < 500) begin tick(); t++; end
        check("bp_valid_seen", 64'(bus.word_valid), 64'd1);
        bus.req = 1'b0;
        s0 = start_cnt;
        repeat (10) tick();
        check("bp_no_starts", 64'(start_cnt - s0), 64'd0);
        check("bp_still_valid", 64'(bus.word_valid), 64'd1);
        bus.word_ready = 1'b1;
        wait_idle("bp_idle");

        // Generator never answers: timeout after TMO wait cycles, then retry
        gen_drop = 1'b1;
        gen_rand = 1'b0; gen_delay = 2; gen_hold = 1;
        bus.req = 1'b1;
        t = 0;
        while (!bus.trn_start && t < 100) begin tick(); t++; end
        check("tmo_first_start", 64'(bus.trn_start), 64'd1);
        repeat (TMO) tick();
        check("tmo_err_before_limit", 64'(bus.err_timeout), 64'd0);
        check("tmo_busy", 64'(bus.busy), 64'd1);
        tick();
        check("tmo_err_set", 64'(bus.err_timeout), 64'd1);
        check("tmo_restart", 64'(bus.trn_start), 64'd1);
        gen_drop = 1'b0;
        run_words(1, 1'b0);
        check("tmo_err_sticky", 64'(bus.err_timeout), 64'd1);

        // Reset after two of four bytes
        bus.req = 1'b1;
        t = 0;
        while (part_q.size() < 2 && t < 200) begin tick(); t++; end
        check("mid_two_bytes", 64'(part_q.size()), 64'd2);
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_clear();
        tick();
        tick();
        check_all_zero("midrst_hold");
        reset = 1'b0;
        run_words(1, 1'b0);

        // Repetition test: four identical bytes
        force_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        run_words(1, 1'b0);
        check("health_model", 64'(bus.health_fail), 64'(exp_health));
        check("health_config", 64'(bus.health_fail), 64'(HEALTH_ON));

        tick();
        check("final_err_cleared", 64'(bus.err_timeout), 64'd0);
        check("final_health_sticky", 64'(bus.health_fail), 64'(exp_health));
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
